// File: rtl/bus_interface_unit.sv
// bus_interface_unit: sequences one core memory request over the TinyTapeout pins
// as address-low, address-high and data phases, returning a one-cycle response.
`timescale 1ns/1ps
module bus_interface_unit #(
    parameter int WAIT_CYCLES = 0,
    parameter int TIMEOUT     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    input  logic        pin_rdy,
    output logic [7:0]  uo_out,
    input  logic [7:0]  uio_in,
    output logic [7:0]  uio_out,
    output logic [7:0]  uio_oe
);
    localparam int WW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] WLOAD = WW'(WAIT_CYCLES);
    localparam logic [TW-1:0] TLIM  = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ADDR_LO, ADDR_HI, DATA} state_t;

    state_t        state, state_nxt;
    logic [15:0]   addr;
    logic [7:0]    wdata;
    logic          rw;
    logic [WW-1:0] wcnt;
    logic [TW-1:0] tcnt, tcnt_inc;
    logic          ok, abort;

    assign busy     = state != IDLE;
    assign tcnt_inc = (tcnt == '1) ? tcnt : tcnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        uo_out    = 8'h00;
        uio_out   = 8'h00;
        uio_oe    = 8'h00;
        ok        = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                state_nxt = req_valid ? ADDR_LO : IDLE;
            end
            ADDR_LO: begin
                uo_out    = addr[7:0];
                uio_out   = {7'b0, rw};
                uio_oe    = 8'h01;
                state_nxt = ADDR_HI;
            end
            ADDR_HI: begin
                uo_out    = addr[15:8];
                uio_out   = {7'b0, rw};
                uio_oe    = 8'h01;
                state_nxt = DATA;
            end
            default: begin
                uo_out  = addr[7:0];
                uio_out = rw ? wdata : 8'h00;
                uio_oe  = {8{rw}};
                // pin_rdy only matters once the fixed wait has drained
                if (wcnt == '0) begin
                    ok    = pin_rdy;
                    abort = !pin_rdy && (TIMEOUT != 0) && (tcnt_inc == TLIM);
                end
                state_nxt = (ok || abort) ? IDLE : DATA;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr      <= '0;
            wdata     <= '0;
            rw        <= 1'b0;
            wcnt      <= '0;
            tcnt      <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 8'h00;
        end else begin
            rsp_valid <= ok || abort;
            rsp_err   <= abort;
            if (state == IDLE && req_valid) begin
                addr  <= req_addr;
                wdata <= req_wdata;
                rw    <= req_rw;
            end
            if (state == ADDR_HI) begin
                wcnt <= WLOAD;
                tcnt <= '0;
            end else if (state == DATA) begin
                if (wcnt != '0) wcnt <= wcnt - 1'b1;
                else if (!pin_rdy) tcnt <= tcnt_inc;
            end
            if (ok && !rw) rsp_rdata <= uio_in;
            if (abort) rsp_rdata <= 8'hFF;
        end
    end
endmodule

// File: tb/tb_bus_interface_unit.sv
// tb_bus_interface_unit: directed and randomized checks of bus_interface_unit
// against a transaction-level model (phase lengths, response values).
`timescale 1ns/1ps
module tb_bus_interface_unit;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        req_valid, req_rw, pin_rdy;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata, uio_in;
    logic        rr [2], rv [2], rerr [2], bsy [2];
    logic [7:0]  rdata [2], uo [2], uout [2], uoe [2];
    logic [7:0]  last_rd [2];
    int          total = 0, passed = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        bus_interface_unit #(.WAIT_CYCLES(g * 2), .TIMEOUT(TIMEOUT)) u_dut (
            .clk(clk), .rst_n(rst_n[g]),
            .req_valid(req_valid), .req_ready(rr[g]), .req_rw(req_rw),
            .req_addr(req_addr), .req_wdata(req_wdata),
            .rsp_valid(rv[g]), .rsp_rdata(rdata[g]), .rsp_err(rerr[g]), .busy(bsy[g]),
            .pin_rdy(pin_rdy), .uo_out(uo[g]), .uio_in(uio_in),
            .uio_out(uout[g]), .uio_oe(uoe[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One complete transaction on DUT d: wt fixed wait cycles, then lows cycles of
    // pin_rdy=0 before ready; lows >= TIMEOUT means the transaction must abort.
    task automatic run_txn(input int d, input logic rw, input logic [15:0] a,
                           input logic [7:0] wd, input int wt, input int lows,
                           input logic [7:0] rd);
        bit   to = lows >= TIMEOUT;
        int   n  = wt + (to ? TIMEOUT : lows + 1);
        logic [7:0] exp_rd = to ? 8'hFF : (rw ? last_rd[d] : rd);
        req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = wd; pin_rdy = 1'b0;
        chk("idle_ready", rr[d], 1);
        tick();
        req_valid = 1'b0; req_addr = 16'($urandom); req_wdata = 8'($urandom); req_rw = 1'($urandom);
        chk("alo_uo", uo[d], a[7:0]);
        chk("alo_oe", uoe[d], 8'h01);
        chk("alo_out", uout[d], {7'b0, rw});
        chk("alo_busy", {bsy[d], rr[d]}, 2'b10);
        tick();
        chk("ahi_uo", uo[d], a[15:8]);
        chk("ahi_oe", uoe[d], 8'h01);
        chk("ahi_out", uout[d], {7'b0, rw});
        tick();
        for (int i = 0; i < n; i++) begin
            chk("data_uo", uo[d], a[7:0]);
            chk("data_oe", uoe[d], rw ? 8'hFF : 8'h00);
            chk("data_out", uout[d], rw ? wd : 8'h00);
            chk("data_norsp", rv[d], 0);
            if (i < wt) begin
                pin_rdy = 1'($urandom); uio_in = 8'($urandom);
            end else if (i - wt < lows) begin
                pin_rdy = 1'b0; uio_in = 8'($urandom);
            end else begin
                pin_rdy = 1'b1; uio_in = rd;
            end
            tick();
        end
        pin_rdy = 1'($urandom); uio_in = 8'($urandom);
        last_rd[d] = exp_rd;
        chk("rsp_valid", rv[d], 1);
        chk("rsp_err", rerr[d], to);
        chk("rsp_rdata", rdata[d], exp_rd);
        chk("rsp_ready", {rr[d], bsy[d], uoe[d]}, {2'b10, 8'h00});
        tick();
        chk("rsp_pulse", rv[d], 0);
        chk("rdata_hold", rdata[d], exp_rd);
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] bb_a [3];
        bb_a = '{16'h1111, 16'h2A2B, 16'hF00D};
        rst_n[0] = 1'b0; rst_n[1] = 1'b0;
        req_valid = 1'b0; req_rw = 1'b0; req_addr = 16'h0; req_wdata = 8'h0;
        pin_rdy = 1'b0; uio_in = 8'h0;
        last_rd[0] = 8'h00; last_rd[1] = 8'h00;
        tick(); tick();
        chk("rst_ready", rr[0], 1);
        chk("rst_busy", bsy[0], 0);
        chk("rst_rsp", {rv[0], rerr[0]}, 2'b00);
        chk("rst_rdata", rdata[0], 8'h00);
        chk("rst_pins", {uo[0], uout[0], uoe[0]}, 24'h0);
        rst_n[0] = 1'b1;
        tick();

        run_txn(0, 1'b0, 16'hBEEF, 8'h00, 0, 0, 8'h5A);
        run_txn(0, 1'b1, 16'h0200, 8'hC3, 0, 0, 8'h77);
        run_txn(0, 1'b0, 16'h4321, 8'h00, 0, 15, 8'h99);
        run_txn(0, 1'b0, 16'h8001, 8'h00, 0, TIMEOUT, 8'h00);

        // back-to-back reads with req_valid held; address changes while busy are ignored
        req_valid = 1'b1; req_rw = 1'b0; pin_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_addr = bb_a[k];
            chk("b2b_ready", rr[0], 1);
            tick();
            req_addr = 16'($urandom);
            chk("b2b_alo", uo[0], bb_a[k][7:0]);
            chk("b2b_busy", rr[0], 0);
            tick();
            chk("b2b_ahi", uo[0], bb_a[k][15:8]);
            tick();
            chk("b2b_data", uo[0], bb_a[k][7:0]);
            uio_in = 8'(8'h3C + k * 8'h11);
            tick();
            chk("b2b_rsp", {rv[0], rerr[0], rr[0]}, 3'b101);
            chk("b2b_rdata", rdata[0], 8'(8'h3C + k * 8'h11));
            if (k == 2) req_valid = 1'b0;
        end
        last_rd[0] = 8'h5E;
        tick();
        chk("b2b_end", {rv[0], bsy[0]}, 2'b00);

        // reset in the middle of a stalled write
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 16'h1234; req_wdata = 8'hAA; pin_rdy = 1'b0;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        chk("mid_oe", uoe[0], 8'hFF);
        chk("mid_out", uout[0], 8'hAA);
        rst_n[0] = 1'b0;
        tick();
        chk("mid_rst1", {bsy[0], rv[0], uoe[0]}, 10'h0);
        tick();
        chk("mid_rst2", {bsy[0], rv[0], uoe[0]}, 10'h0);
        rst_n[0] = 1'b1;
        tick();
        chk("mid_after", {rv[0], rr[0], uoe[0]}, {2'b01, 8'h00});
        last_rd[0] = 8'h00;

        // fixed wait of 2 on the second instance, with the first held in reset
        rst_n[0] = 1'b0; rst_n[1] = 1'b1;
        run_txn(1, 1'b0, 16'hCAFE, 8'h00, 2, 3, 8'hD7);
        run_txn(1, 1'b0, 16'h0F0F, 8'h00, 2, TIMEOUT + 2, 8'h00);
        run_txn(1, 1'b1, 16'h7777, 8'h12, 2, 1, 8'h34);
        rst_n[1] = 1'b0; rst_n[0] = 1'b1;
        last_rd[0] = 8'h00;
        tick();

        for (int t = 0; t < 24; t++) begin
            logic rw = 1'($urandom);
            int   lows = (!rw && $urandom_range(0, 5) == 0) ? TIMEOUT + $urandom_range(0, 4)
                                                           : $urandom_range(0, 3);
            run_txn(0, rw, 16'($urandom), 8'($urandom), 0, lows, 8'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
